// File: rtl/cpu_dbg_pkg.sv
// Debug-controller shared types: run-control FSM encoding and the
// control-unit fetch state code shared with the control unit and display.
package cpu_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    STEP_CYC = 3'd2,
    STEP_INS = 3'd3,
    BREAK    = 3'd4
  } dbg_state_e;

  localparam logic [3:0] FETCH_STATE = 4'd0;

endpackage

// File: rtl/dbg_event_counter.sv
// Wrapping event counter with synchronous clear; clear beats increment.
module dbg_event_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run/step/breakpoint sequencer producing the datapath clock-enable,
// plus cycle and retired-instruction counters for the debug display.
module cpu_run_controller
  import cpu_dbg_pkg::*;
#(
  parameter int                 ADDR_W      = 32,
  parameter int                 STATE_W     = 4,
  parameter logic [STATE_W-1:0] FETCH_STATE = cpu_dbg_pkg::FETCH_STATE,
  parameter int                 CNT_W       = 32,
  parameter int                 MAX_STEP    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cont,
  input  logic               step,
  input  logic               step_mode,
  input  logic               bp_en,
  input  logic [ADDR_W-1:0]  bp_addr,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [STATE_W-1:0] cpu_state,
  input  logic               cnt_clr,
  output logic               cpu_ce,
  output logic               running,
  output logic               bp_halt,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt
);

  localparam int SC_W = $clog2(MAX_STEP + 1);
  localparam logic [SC_W-1:0] STEP_LIM = SC_W'(MAX_STEP);

  dbg_state_e      state_q;
  dbg_state_e      state_d;
  logic            step_q;
  logic            bp_skip;
  logic [SC_W-1:0] step_cnt;
  logic            step_edge;
  logic            is_fetch;
  logic            bp_hit;
  logic            brk_entry;

  assign step_edge = step & ~step_q;
  assign is_fetch  = (cpu_state == FETCH_STATE);
  assign bp_hit    = bp_en & is_fetch & (pc == bp_addr) & ~bp_skip;
  assign brk_entry = (state_d == BREAK) && (state_q != BREAK);

  always_comb begin
    state_d = state_q;
    cpu_ce  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cont)
          state_d = RUN;
        else if (step_edge)
          state_d = step_mode ? STEP_INS : STEP_CYC;
      end
      RUN: begin
        cpu_ce = ~bp_hit;
        if (bp_hit)
          state_d = BREAK;
        else if (!cont)
          state_d = IDLE;
      end
      STEP_CYC: begin
        cpu_ce  = 1'b1;
        state_d = IDLE;
      end
      STEP_INS: begin
        // first cycle always runs, even when it is itself the fetch
        if (step_cnt == '0)
          cpu_ce = 1'b1;
        else if (is_fetch || step_cnt == STEP_LIM)
          state_d = IDLE;
        else
          cpu_ce = 1'b1;
      end
      BREAK: begin
        if (!cont)
          state_d = IDLE;
        else if (step_edge)
          state_d = step_mode ? STEP_INS : STEP_CYC;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      step_q   <= 1'b0;
      bp_skip  <= 1'b0;
      step_cnt <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step;
      if (brk_entry)
        bp_skip <= 1'b1;
      else if (cpu_ce && is_fetch)
        bp_skip <= 1'b0;
      if (state_d == STEP_INS && state_q != STEP_INS)
        step_cnt <= '0;
      else if (state_q == STEP_INS)
        step_cnt <= step_cnt + 1'b1;
    end
  end

  assign running = (state_q == RUN) ||
                   (state_q == STEP_CYC) ||
                   (state_q == STEP_INS);
  assign bp_halt = (state_q == BREAK);

  dbg_event_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cpu_ce),
    .clr (cnt_clr),
    .cnt (cycle_cnt)
  );

  dbg_event_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cpu_ce & is_fetch),
    .clr (cnt_clr),
    .cnt (instr_cnt)
  );

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: toy 4-state datapath, per-cycle
// expected-output scoreboard and counter reference model.
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cont = 1'b0;
  logic        step = 1'b0;
  logic        step_mode = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'h0;
  logic [31:0] pc;
  logic [3:0]  cpu_state;
  logic        cnt_clr = 1'b0;
  logic        cpu_ce;
  logic        running;
  logic        bp_halt;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  logic [3:0]  dp_state = 4'd0;
  logic [31:0] dp_pc = 32'h0;
  logic        st_ovr_en = 1'b0;
  logic [3:0]  st_ovr = 4'd0;

  int n_tests = 0;
  int n_fail = 0;
  int m_cyc = 0;
  int m_ins = 0;

  typedef struct {
    logic ce;
    logic run;
    logic halt;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign cpu_state = st_ovr_en ? st_ovr : dp_state;
  assign pc = dp_pc;

  // toy datapath: 4 states per instruction, 8-instruction loop
  always @(posedge clk) begin
    if (cpu_ce && !st_ovr_en) begin
      dp_state <= (dp_state == 4'd3) ? 4'd0 : dp_state + 4'd1;
      if (dp_state == 4'd3)
        dp_pc <= (dp_pc + 32'd4) & 32'h1F;
    end
  end

  cpu_run_controller dut (
    .clk       (clk),
    .rst       (rst),
    .cont      (cont),
    .step      (step),
    .step_mode (step_mode),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .cpu_state (cpu_state),
    .cnt_clr   (cnt_clr),
    .cpu_ce    (cpu_ce),
    .running   (running),
    .bp_halt   (bp_halt),
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input string tag, input logic c, input logic s,
                      input logic clr, input logic e_ce,
                      input logic e_run, input logic e_halt);
    exp_t e;
    logic fetch;
    @(posedge clk);
    #1;
    cont = c;
    step = s;
    cnt_clr = clr;
    e.ce = e_ce;
    e.run = e_run;
    e.halt = e_halt;
    sb.push_back(e);
    fetch = (cpu_state == 4'd0);
    @(negedge clk);
    check({tag, "_cyc"}, cycle_cnt, m_cyc);
    check({tag, "_ins"}, instr_cnt, m_ins);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_ce"}, cpu_ce, e.ce);
      check({tag, "_run"}, running, e.run);
      check({tag, "_halt"}, bp_halt, e.halt);
    end
    if (clr) begin
      m_cyc = 0;
      m_ins = 0;
    end else if (e_ce) begin
      m_cyc++;
      if (fetch) m_ins++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ins0;
    #2;
    check("rst_ce", cpu_ce, 0);
    check("rst_run", running, 0);
    check("rst_halt", bp_halt, 0);
    check("rst_cyc", cycle_cnt, 0);
    check("rst_ins", instr_cnt, 0);
    #20 rst = 1'b1;

    // free run for 10 enabled cycles
    tick("t1_go", 1, 0, 0, 0, 0, 0);
    repeat (9) tick("t1_run", 1, 0, 0, 1, 1, 0);
    tick("t1_drop", 0, 0, 0, 1, 1, 0);
    tick("t1_idle", 0, 0, 0, 0, 0, 0);
    check("t1_cyc10", cycle_cnt, 10);
    check("t1_ins3", instr_cnt, 3);

    // breakpoint at 0x10, resume once, re-arm
    bp_en = 1'b1;
    bp_addr = 32'h10;
    tick("t4_go", 1, 0, 0, 0, 0, 0);
    repeat (6) tick("t4_run", 1, 0, 0, 1, 1, 0);
    tick("t4_hit", 1, 0, 0, 0, 1, 0);
    tick("t4_brk", 1, 0, 0, 0, 0, 1);
    tick("t4_brk_off", 0, 0, 0, 0, 0, 1);
    tick("t4_idle", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++)
      tick("t4_resume", 1, (i == 5), 0, 1, 1, 0);
    tick("t4_rehit", 1, 0, 0, 0, 1, 0);
    tick("t4_brk2", 0, 0, 0, 0, 0, 1);
    tick("t4_idle2", 0, 0, 0, 0, 0, 0);
    bp_en = 1'b0;

    // cycle step, long pulse then three short ones
    step_mode = 1'b0;
    tick("t2_edge", 0, 1, 0, 0, 0, 0);
    tick("t2_step", 0, 1, 0, 1, 1, 0);
    repeat (3) tick("t2_hold", 0, 1, 0, 0, 0, 0);
    tick("t2_rel", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick("t2b_edge", 0, 1, 0, 0, 0, 0);
      tick("t2b_step", 0, 0, 0, 1, 1, 0);
      tick("t2b_idle", 0, 0, 0, 0, 0, 0);
    end

    // instruction step over states 0,1,2,3,0
    step_mode = 1'b1;
    ins0 = m_ins;
    tick("t3_edge", 0, 1, 0, 0, 0, 0);
    tick("t3_s0", 0, 1, 0, 1, 1, 0);
    tick("t3_s1", 0, 0, 0, 1, 1, 0);
    tick("t3_s2", 0, 0, 0, 1, 1, 0);
    tick("t3_s3", 0, 0, 0, 1, 1, 0);
    tick("t3_end", 0, 0, 0, 0, 1, 0);
    tick("t3_idle", 0, 0, 0, 0, 0, 0);
    check("t3_ins1", instr_cnt, ins0 + 1);

    // instruction step with state stuck: timeout after 8 cycles
    st_ovr_en = 1'b1;
    st_ovr = 4'd2;
    tick("t3v_edge", 0, 1, 0, 0, 0, 0);
    repeat (8) tick("t3v_run", 0, 0, 0, 1, 1, 0);
    tick("t3v_tmo", 0, 0, 0, 0, 1, 0);
    tick("t3v_idle", 0, 0, 0, 0, 0, 0);
    st_ovr_en = 1'b0;

    // cont and step edge together: run wins; then clear vs increment
    step_mode = 1'b0;
    tick("t5_both", 1, 1, 0, 0, 0, 0);
    tick("t5_run1", 1, 1, 0, 1, 1, 0);
    tick("t5_run2", 1, 0, 0, 1, 1, 0);
    tick("t5_clr", 1, 0, 1, 1, 1, 0);
    tick("t5_drop", 0, 0, 0, 1, 1, 0);
    check("t5_clr_cyc", cycle_cnt, 0);
    check("t5_clr_ins", instr_cnt, 0);
    tick("t5_idle", 0, 0, 0, 0, 0, 0);

    // async reset in the middle of an instruction step
    step_mode = 1'b1;
    st_ovr_en = 1'b1;
    st_ovr = 4'd2;
    tick("t6_edge", 0, 1, 0, 0, 0, 0);
    tick("t6_s0", 0, 0, 0, 1, 1, 0);
    tick("t6_s1", 0, 0, 0, 1, 1, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("t6_ce", cpu_ce, 0);
    check("t6_run", running, 0);
    check("t6_halt", bp_halt, 0);
    check("t6_cyc", cycle_cnt, 0);
    check("t6_ins", instr_cnt, 0);
    m_cyc = 0;
    m_ins = 0;
    step = 1'b0;
    cont = 1'b0;
    st_ovr_en = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    tick("t6_idle", 0, 0, 0, 0, 0, 0);
    tick("t6_go", 1, 0, 0, 0, 0, 0);
    tick("t6_run", 1, 0, 0, 1, 1, 0);
    tick("t6_drop", 0, 0, 0, 1, 1, 0);
    tick("t6_end", 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
